// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM state and SCL quarter-phase encodings shared by the I2C master and slave benches
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_e;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qtr_e;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: one-cycle tick every CLK_DIV clocks while enabled, counter held at zero otherwise
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == W'(CLK_DIV - 1);
  always_comb cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master; START, address+rw, one data byte, STOP, one response pulse
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy
);
  state_e     state_q, state_d;
  qtr_e       qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d, rsp_data_q, rsp_data_d;
  logic       rw_q, rw_d, nack_q, nack_d, scl_q, scl_d, oe_q, oe_d;
  logic       busy_q, busy_d, ready_q, ready_d, rsp_valid_q, done, tick;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rw_d    = rw_q;
    nack_d  = nack_q;
    done    = 1'b0;
    if (cmd_valid && ready_q) begin
      state_d = START;
      qtr_d   = Q0;
      bit_d   = '0;
      sh_d    = {cmd_addr, cmd_rw};
      data_d  = cmd_data;
      rw_d    = cmd_rw;
      nack_d  = 1'b0;
    end else if (tick) begin
      qtr_d = qtr_e'(qtr_q + 2'd1);
      // sda_i is only ever looked at mid-high-phase of SCL
      if (qtr_q == Q2 && (state_q == ADDR_ACK || (state_q == DATA_ACK && !rw_q))) nack_d = sda_i;
      if (qtr_q == Q2 && state_q == DATA && rw_q) sh_d = {sh_q[6:0], sda_i};
      if (qtr_q == Q3) begin
        if (state_q == ADDR || (state_q == DATA && !rw_q)) sh_d = {sh_q[6:0], 1'b0};
        if (state_q == ADDR || state_q == DATA) bit_d = bit_q + 3'd1;
        case (state_q)
          START:    state_d = ADDR;
          ADDR:     state_d = bit_q == 3'd7 ? ADDR_ACK : ADDR;
          ADDR_ACK: begin
            state_d = nack_q ? STOP : DATA;
            sh_d    = data_q;
          end
          DATA:     state_d = bit_q == 3'd7 ? DATA_ACK : DATA;
          DATA_ACK: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            done    = 1'b1;
          end
          default:  state_d = IDLE;
        endcase
      end
    end
    // Pin levels are derived from the next state so they come straight out of flops
    scl_d = state_d == START ? qtr_d != Q3 :
            state_d == STOP  ? qtr_d != Q0 :
            state_d == IDLE  ? 1'b1 : (qtr_d == Q1 || qtr_d == Q2);
    oe_d  = state_d == START ? qtr_d != Q0 :
            state_d == STOP  ? qtr_d != Q3 :
            state_d == ADDR  ? !sh_d[7] :
            state_d == DATA  ? !rw_d && !sh_d[7] : 1'b0;
    busy_d     = state_d != IDLE;
    ready_d    = state_d == IDLE && !done;
    rsp_data_d = done && rw_q && !nack_q ? sh_q : 8'h00;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      qtr_q       <= Q0;
      bit_q       <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      scl_q       <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      scl_q       <= scl_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rsp_valid_q <= done;
      rsp_data_q  <= rsp_data_d;
    end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = nack_q;
  assign scl_o     = scl_q;
  assign sda_oe    = oe_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed transactions against a behavioural I2C target, scoreboard-checked responses
module tb_i2c_master_ctrl;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       scl_o;
  logic       sda_oe;
  logic       sda_line;
  logic       busy;

  logic       sda_drv = 1'b1;
  logic       slave_present = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] rx = 8'h00;
  logic [7:0] got_addr = 8'hEE;
  logic [7:0] got_data = 8'hEE;
  logic       got_mack = 1'b0;
  int         ph = 4;
  int         bitn = 0;

  int cyc = 0;
  int last_rsp_cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       nack;
    int         kind;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sb[$];

  assign sda_line = sda_oe ? 1'b0 : sda_drv;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_rw   (cmd_rw),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_nack (rsp_nack),
    .scl_o    (scl_o),
    .sda_oe   (sda_oe),
    .sda_i    (sda_line),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target: ph 0 address, 1 address ACK, 2 data, 3 data ACK, 4 inactive
  always @(scl_o or sda_line or rst) begin
    if (rst) begin
      ph = 4;
      sda_drv = 1'b1;
    end else if (scl_o && prev_scl && prev_sda && !sda_line) begin
      ph = 0;
      bitn = 0;
      rx = 8'h00;
      got_addr = 8'hEE;
      got_data = 8'hEE;
      got_mack = 1'b0;
      sda_drv = 1'b1;
    end else if (scl_o && !prev_scl) begin
      if (ph == 0 || (ph == 2 && !rd)) begin
        rx = {rx[6:0], sda_line};
        bitn++;
      end else if (ph == 2) bitn++;
      else if (ph == 3 && rd) got_mack = sda_line;
      if (ph == 0 && bitn == 8) begin
        got_addr = rx;
        rd = rx[0];
      end
    end else if (!scl_o && prev_scl) begin
      if (ph == 0 && bitn == 8) begin
        ph = 1;
        sda_drv = !slave_present;
      end else if (ph == 1) begin
        ph = 2;
        bitn = 0;
        rx = 8'h00;
        sda_drv = (rd && slave_present) ? rd_byte[7] : 1'b1;
      end else if (ph == 2 && bitn == 8) begin
        ph = 3;
        if (!rd) got_data = rx;
        sda_drv = rd;
      end else if (ph == 2 && rd) sda_drv = rd_byte[7 - bitn];
      else if (ph == 3) begin
        ph = 4;
        sda_drv = 1'b1;
      end
    end
    prev_scl = scl_o;
    prev_sda = sda_line;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rsp_expected", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("rsp_nack", {31'd0, rsp_nack}, {31'd0, e.nack});
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.rdata});
          chk("addr_byte", {24'd0, got_addr}, {24'd0, e.addr_b});
          chk("bus_idle", {30'd0, scl_o, sda_oe}, 2);
          if (e.kind == 1) chk("wr_byte", {24'd0, got_data}, {24'd0, e.wdata});
          if (e.kind == 2) chk("master_nack", {31'd0, got_mack}, 1);
        end
        last_rsp_cyc = cyc;
      end
    end
  endtask

  task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] d,
                      input bit expect_rsp, input bit hold, input bit chk_gap);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_rw = rw;
    cmd_data = d;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("accept_wait", {31'd0, cmd_ready}, 1);
    if (chk_gap) chk("b2b_gap", cyc - last_rsp_cyc, 1);
    e.addr_b = {a, rw};
    e.wdata = d;
    e.nack = !slave_present;
    e.rdata = (rw && slave_present) ? rd_byte : 8'h00;
    e.kind = !slave_present ? 0 : rw ? 2 : 1;
    e.lat = (slave_present ? 80 : 44) * CLK_DIV;
    e.acc = cyc + 1;
    if (expect_rsp) sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", {31'd0, scl_o}, 1);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_nack", {31'd0, rsp_nack}, 0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);

    send(7'h3C, 1'b0, 8'hA5, 1, 0, 0);
    wait_idle();

    rd_byte = 8'h5A;
    send(7'h3C, 1'b1, 8'h00, 1, 0, 0);
    wait_idle();

    slave_present = 1'b0;
    send(7'h10, 1'b0, 8'h77, 1, 0, 0);
    wait_idle();
    slave_present = 1'b1;

    send(7'h55, 1'b0, 8'h0F, 1, 0, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("busy_mid", {31'd0, busy}, 1);
    chk("ready_mid", {31'd0, cmd_ready}, 0);
    cmd_valid = 1'b1;
    cmd_addr = 7'h22;
    cmd_rw = 1'b1;
    cmd_data = 8'hFF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();

    send(7'h3C, 1'b0, 8'h00, 0, 0, 0);
    repeat (52 * CLK_DIV + 12) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    chk("pre_rst_scl", {31'd0, scl_o}, 0);
    chk("pre_rst_sda_oe", {31'd0, sda_oe}, 1);
    rst = 1'b1;
    #1;
    chk("abort_scl", {31'd0, scl_o}, 1);
    chk("abort_sda_oe", {31'd0, sda_oe}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, cmd_ready}, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    send(7'h3C, 1'b0, 8'hC3, 1, 0, 0);
    wait_idle();

    rd_byte = 8'hC6;
    send(7'h3C, 1'b1, 8'h00, 1, 1, 0);
    send(7'h12, 1'b0, 8'h34, 1, 0, 1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning system clocks per SCL quarter-period (50 MHz / (4*125) = 100 kHz SCL).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-005 SHALL have ports cmd_addr in 7 / cmd_rw in 1 (1=read) / cmd_data in 8  command payload (7-bit target address, direction, write byte).
REQ-006 SHALL have ports rsp_valid out 1 / rsp_data out 8 / rsp_nack out 1  one-cycle completion pulse, read byte, NACK flag.
REQ-007 SHALL have ports scl_o out 1, sda_oe out 1 (1 = pull SDA low), sda_i in 1  bus pins; SDA open-drain, released when sda_oe=0.
REQ-008 SHALL have port busy  output  1  high from command acceptance through end of STOP.

Function
REQ-009 SHALL accept a command only on a cycle with cmd_valid && cmd_ready; cmd_ready=1 only in IDLE; payload latched on that cycle.
REQ-010 SHALL run FSM IDLE -> START -> ADDR -> ADDR_ACK -> DATA -> DATA_ACK -> STOP -> IDLE, each bit spanning 4 quarter-ticks.
REQ-011 SHALL generate a one-cycle quarter tick every CLK_DIV clocks while not IDLE; counter cleared on acceptance so first tick comes CLK_DIV clocks later.
REQ-012 START: SDA low while SCL high, then SCL low; STOP: SDA low, SCL high, then SDA released.
REQ-013 SHALL shift MSB first; SDA changes only while SCL low; sda_i sampled on quarter 2 (SCL high).
REQ-014 ADDR SHALL send {cmd_addr, cmd_rw} (8 bits).
REQ-015 ADDR_ACK: SDA released; sda_i=1 at sample sets rsp_nack=1 and FSM SHALL skip DATA/DATA_ACK and go to STOP.
REQ-016 Write: DATA sends cmd_data; DATA_ACK samples target ACK; sda_i=1 sets rsp_nack=1.
REQ-017 Read: DATA releases SDA and shifts in 8 bits; DATA_ACK SHALL drive NACK (SDA released) since single-byte read.
REQ-018 rsp_valid SHALL pulse exactly one cycle on the cycle STOP completes; rsp_data valid only then (read byte, 0x00 for write or address NACK); FSM in IDLE the next cycle.
REQ-019 Transaction latency without NACK SHALL be exactly (1+8+1+8+1+1)*4*CLK_DIV = 80*CLK_DIV clocks from acceptance to rsp_valid.
REQ-020 Address NACK transaction SHALL last exactly (1+8+1+1)*4*CLK_DIV = 44*CLK_DIV clocks.
REQ-021 cmd_valid asserted while busy SHALL be ignored (no latch, no state change); command must be held until accepted.
REQ-022 Bit counter SHALL be 3 bits, wrap 7->0 advancing state; tick counter width $clog2(CLK_DIV).

Reset
REQ-023 On rst=1, immediately: state IDLE, scl_o=1, sda_oe=0, cmd_ready=1 after release, busy=0, rsp_valid=0, rsp_nack=0, rsp_data=0x00, counters 0.
REQ-024 Reset mid-transaction SHALL abort without STOP; bus released (SCL and SDA high) asynchronously; no rsp_valid generated.

Structure
REQ-025 Package i2c_pkg SHALL hold the FSM state enum and quarter-phase enum, shared with i2c_slave benches.
REQ-026 Quarter tick counter SHALL be one sub-module i2c_tick_gen (inputs clk, rst, en; output tick).
REQ-027 All outputs SHALL be registered; no combinational path from sda_i to any output.

Verification
REQ-028 Write addr 0x3C data 0xA5, model ACKs -> SDA bits 0x78 then 0xA5, rsp_valid after 80*CLK_DIV clocks, rsp_nack=0.
REQ-029 Read addr 0x3C, model returns 0x5A -> first byte 0x79, rsp_data=0x5A, master NACK on 9th bit, rsp_nack=0.
REQ-030 Write addr 0x10, no ACK (SDA pulled up) -> STOP after address, rsp_nack=1, rsp_valid after 44*CLK_DIV clocks.
REQ-031 cmd_valid pulsed while busy with different payload -> ignored; in-flight transaction bytes unchanged.
REQ-032 rst asserted during DATA bit 3 -> same cycle scl_o=1, sda_oe=0; no rsp_valid; next command completes normally.
REQ-033 Back-to-back commands (cmd_valid held) -> second accepted the cycle after rsp_valid; SCL high between transactions.
